bpu_btb: RTL

Parametrised branch predictor for the fetch stage, succeeding the combinational branch-resolution unit in the decoder. It holds a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating direction counters. It supplies a same-cycle predicted next PC for the fetch PC. It is trained by resolved control-flow outcomes from decode/execute. It raises a registered mispredict/redirect one cycle after a wrong prediction is resolved.

---
 rtl/bpu_btb_pkg.sv | 16 +
 rtl/sat_ctr2.sv | 19 +
 rtl/bpu_btb.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bpu_btb_pkg.sv
// Shared constants for the fetch-stage branch predictor: counter encodings,
// reset vector and the default table depth.
package bpu_btb_pkg;

    localparam int unsigned BTB_ENTRIES_DEFAULT = 16;

    // 2-bit direction counter; bit 1 is the predicted direction
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam logic [31:0] RESET_PC   = 32'h8000_0000;
    localparam logic        RST_ENABLE = 1'b0;

endpackage

// File: rtl/sat_ctr2.sv
// Next-state logic for a 2-bit saturating direction counter.
module sat_ctr2
    import bpu_btb_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/bpu_btb.sv
// Direct-mapped BTB with 2-bit direction counters: same-cycle next-PC prediction,
// training from resolved control flow and a registered mispredict/redirect.
module bpu_btb
    import bpu_btb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned ENTRIES = BTB_ENTRIES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_npc_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_is_ctrl_i,
    input  logic              upd_uncond_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic [ADDR_W-1:0] upd_pred_npc_i,
    output logic              mispredict_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic [31:0]       mispredict_cnt_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic               r_uncond [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    logic               r_mispredict;
    logic [ADDR_W-1:0]  r_redirect;
    logic [31:0]        r_cnt;

    logic [IDX_W-1:0]   w_lk_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic               w_lk_hit;
    logic [IDX_W-1:0]   w_up_idx;
    logic [TAG_W-1:0]   w_up_tag;
    logic               w_up_hit;
    logic               w_up_taken;
    logic [1:0]         w_up_ctr_nxt;
    logic [ADDR_W-1:0]  w_actual;
    logic               w_mispredict;
    logic               w_unused_lsb;

    assign w_lk_idx = lookup_pc_i[IDX_W+1:2];
    assign w_lk_tag = lookup_pc_i[ADDR_W-1:IDX_W+2];
    assign w_up_idx = upd_pc_i[IDX_W+1:2];
    assign w_up_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
    assign w_unused_lsb = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

    // Lookup reads pre-update state, so a same-index update is invisible this cycle
    assign w_lk_hit     = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign pred_taken_o = w_lk_hit && (r_uncond[w_lk_idx] || r_ctr[w_lk_idx][1]);
    assign pred_npc_o   = pred_taken_o ? r_target[w_lk_idx] : lookup_pc_i + ADDR_W'(4);

    assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_taken = upd_is_ctrl_i && upd_taken_i;

    sat_ctr2 u_sat_ctr2 (
        .ctr_i   (r_ctr[w_up_idx]),
        .taken_i (upd_taken_i),
        .ctr_o   (w_up_ctr_nxt)
    );

    assign w_actual     = w_up_taken ? upd_target_i : upd_pc_i + ADDR_W'(4);
    assign w_mispredict = upd_valid_i && (w_actual != upd_pred_npc_i);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_valid <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_uncond[i] <= 1'b0;
                r_ctr[i]    <= CTR_WNT;
            end
        end else if (flush_i) begin
            // Flush wins over a same-cycle update; counters are kept
            r_valid <= '0;
        end else if (upd_valid_i) begin
            if (upd_is_ctrl_i) begin
                if (w_up_hit) begin
                    r_ctr[w_up_idx] <= w_up_ctr_nxt;
                    if (upd_taken_i) begin
                        r_target[w_up_idx] <= upd_target_i;
                        r_uncond[w_up_idx] <= upd_uncond_i;
                    end
                end else if (upd_taken_i) begin
                    r_valid[w_up_idx]  <= 1'b1;
                    r_tag[w_up_idx]    <= w_up_tag;
                    r_target[w_up_idx] <= upd_target_i;
                    r_uncond[w_up_idx] <= upd_uncond_i;
                    r_ctr[w_up_idx]    <= CTR_WT;
                end
            end else if (w_up_hit) begin
                // Non-control instruction hit a stale or aliased entry
                r_valid[w_up_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_mispredict <= 1'b0;
            r_redirect   <= ADDR_W'(RESET_PC);
            r_cnt        <= '0;
        end else begin
            r_mispredict <= w_mispredict;
            if (w_mispredict) begin
                r_redirect <= w_actual;
                r_cnt      <= r_cnt + 32'd1;
            end
        end
    end

    assign mispredict_o     = r_mispredict;
    assign redirect_pc_o    = r_redirect;
    assign mispredict_cnt_o = r_cnt;

endmodule
